// File: rtl/processor_trace_monitor_if.sv
// Trace, control and readout signals of the processor trace monitor.
// The processor/test side is the master; the monitor is the slave.
interface processor_trace_monitor_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] Present_Inst_Addr;
   logic [DATA_W-1:0] Inst;
   logic              Reg_Write;
   logic [4:0]        Dest_Addr;
   logic [DATA_W-1:0] Write_Data;
   logic              Arm;
   logic [1:0]        Trig_Mode;
   logic [DATA_W-1:0] Trig_Addr;
   logic [4:0]        Trig_Reg;
   logic              Rd_Ready;
   logic              Rd_Valid;
   logic [DATA_W-1:0] Rd_PC;
   logic [DATA_W-1:0] Rd_Inst;
   logic [DATA_W-1:0] Rd_Data;
   logic              Rd_Wb;
   logic [4:0]        Rd_Dest;
   logic              Armed;
   logic              Triggered;
   logic              Done;
   logic [CW-1:0]     Entry_Count;
   logic [31:0]       Cycle_Count;

   modport master (
      output Present_Inst_Addr, Inst, Reg_Write, Dest_Addr, Write_Data,
             Arm, Trig_Mode, Trig_Addr, Trig_Reg, Rd_Ready,
      input  Rd_Valid, Rd_PC, Rd_Inst, Rd_Data, Rd_Wb, Rd_Dest,
             Armed, Triggered, Done, Entry_Count, Cycle_Count
   );

   modport slave (
      input  Present_Inst_Addr, Inst, Reg_Write, Dest_Addr, Write_Data,
             Arm, Trig_Mode, Trig_Addr, Trig_Reg, Rd_Ready,
      output Rd_Valid, Rd_PC, Rd_Inst, Rd_Data, Rd_Wb, Rd_Dest,
             Armed, Triggered, Done, Entry_Count, Cycle_Count
   );
endinterface

// File: rtl/processor_trace_monitor.sv
// Circular retirement-trace buffer: arm, trigger, post-trigger capture,
// then oldest-first valid/ready readout of the captured window.
module processor_trace_monitor #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4
) (
   input logic                    Clk,
   input logic                    Reset,
   processor_trace_monitor_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     rd_idx_q, rd_idx_d;
   logic [CW-1:0]     post_q, post_d;
   logic [31:0]       cycle_q, cycle_d;
   logic [1:0]        mode_q, mode_d;
   logic              capture, trig_hit, full, rd_valid, rd_fire;
   logic [AW-1:0]     rd_addr;

   logic [DATA_W-1:0] pc_mem   [DEPTH];
   logic [DATA_W-1:0] inst_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic              wb_mem   [DEPTH];
   logic [4:0]        dest_mem [DEPTH];

   // Once full, the oldest entry sits at the write pointer.
   assign full     = (count_q == CW'(DEPTH));
   assign rd_addr  = (full ? wr_ptr_q : '0) + rd_idx_q[AW-1:0];
   assign rd_valid = (state_q == DONE) && (rd_idx_q != count_q);
   assign rd_fire  = rd_valid && bus.Rd_Ready && !bus.Arm;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      rd_idx_d = rd_idx_q;
      post_d   = post_q;
      cycle_d  = cycle_q;
      mode_d   = mode_q;
      capture  = 1'b0;
      trig_hit = 1'b0;

      case (mode_q)
         2'd0:    trig_hit = (bus.Present_Inst_Addr == bus.Trig_Addr);
         2'd1:    trig_hit = bus.Reg_Write && (bus.Dest_Addr == bus.Trig_Reg);
         2'd2:    trig_hit = (cycle_q == '0);
         default: trig_hit = 1'b0;
      endcase

      if (bus.Arm) begin
         state_d  = ARMED;
         wr_ptr_d = '0;
         count_d  = '0;
         rd_idx_d = '0;
         post_d   = '0;
         cycle_d  = '0;
         mode_d   = bus.Trig_Mode;
      end else begin
         case (state_q)
            ARMED, POST: begin
               capture  = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               cycle_d  = cycle_q + 32'd1;
               if (!full) count_d = count_q + CW'(1);
               if (state_q == ARMED) begin
                  if (trig_hit) begin
                     state_d = (POST_TRIG == 0) ? DONE : POST;
                     post_d  = CW'(POST_TRIG);
                  end
               end else begin
                  post_d = post_q - CW'(1);
                  if (post_q == CW'(1)) state_d = DONE;
               end
            end
            DONE: begin
               if (rd_fire) rd_idx_d = rd_idx_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         rd_idx_q <= '0;
         post_q   <= '0;
         cycle_q  <= '0;
         mode_q   <= 2'd3;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         rd_idx_q <= rd_idx_d;
         post_q   <= post_d;
         cycle_q  <= cycle_d;
         mode_q   <= mode_d;
      end
   end

   // NOTE: storage is deliberately not reset; Entry_Count and Rd_Valid gate every view of it.
   always_ff @(posedge Clk) begin
      if (capture) begin
         pc_mem[wr_ptr_q]   <= bus.Present_Inst_Addr;
         inst_mem[wr_ptr_q] <= bus.Inst;
         data_mem[wr_ptr_q] <= bus.Write_Data;
         wb_mem[wr_ptr_q]   <= bus.Reg_Write;
         dest_mem[wr_ptr_q] <= bus.Dest_Addr;
      end
   end

   assign bus.Rd_Valid    = rd_valid;
   assign bus.Rd_PC       = rd_valid ? pc_mem[rd_addr]   : '0;
   assign bus.Rd_Inst     = rd_valid ? inst_mem[rd_addr] : '0;
   assign bus.Rd_Data     = rd_valid ? data_mem[rd_addr] : '0;
   assign bus.Rd_Wb       = rd_valid ? wb_mem[rd_addr]   : 1'b0;
   assign bus.Rd_Dest     = rd_valid ? dest_mem[rd_addr] : '0;
   assign bus.Armed       = (state_q == ARMED);
   assign bus.Triggered   = (state_q == POST) || (state_q == DONE);
   assign bus.Done        = (state_q == DONE);
   assign bus.Entry_Count = count_q;
   assign bus.Cycle_Count = cycle_q;
endmodule

// File: tb/tb_processor_trace_monitor.sv
// Directed bench for processor_trace_monitor: one instance with POST_TRIG=4,
// one with POST_TRIG=0, sharing the same stimulus.
module tb_processor_trace_monitor;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] pc;
   logic        rw;
   logic [4:0]  dest;
   logic        arm;
   logic [1:0]  mode;
   logic [31:0] taddr;
   logic [4:0]  treg;
   logic        rdy;
   logic        sel;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   function automatic logic [31:0] inst_of(input logic [31:0] p);
      return {p[15:0], ~p[15:0]};
   endfunction

   function automatic logic [31:0] data_of(input logic [31:0] p);
      return p + 32'h1000;
   endfunction

   processor_trace_monitor_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
   processor_trace_monitor_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();

   assign bus0.Present_Inst_Addr = pc;
   assign bus0.Inst              = inst_of(pc);
   assign bus0.Reg_Write         = rw;
   assign bus0.Dest_Addr         = dest;
   assign bus0.Write_Data        = data_of(pc);
   assign bus0.Arm               = arm;
   assign bus0.Trig_Mode         = mode;
   assign bus0.Trig_Addr         = taddr;
   assign bus0.Trig_Reg          = treg;
   assign bus0.Rd_Ready          = rdy;

   assign bus1.Present_Inst_Addr = pc;
   assign bus1.Inst              = inst_of(pc);
   assign bus1.Reg_Write         = rw;
   assign bus1.Dest_Addr         = dest;
   assign bus1.Write_Data        = data_of(pc);
   assign bus1.Arm               = arm;
   assign bus1.Trig_Mode         = mode;
   assign bus1.Trig_Addr         = taddr;
   assign bus1.Trig_Reg          = treg;
   assign bus1.Rd_Ready          = rdy;

   processor_trace_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(4)) u_dut0 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus0)
   );

   processor_trace_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(0)) u_dut1 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus1)
   );

   // Observed view of whichever instance sel picks.
   logic        rv, rwb, armed, trig, done;
   logic [31:0] rpc, rinst, rdata, cyc;
   logic [4:0]  rdest, cnt;
   assign rv    = sel ? bus1.Rd_Valid    : bus0.Rd_Valid;
   assign rpc   = sel ? bus1.Rd_PC       : bus0.Rd_PC;
   assign rinst = sel ? bus1.Rd_Inst     : bus0.Rd_Inst;
   assign rdata = sel ? bus1.Rd_Data     : bus0.Rd_Data;
   assign rwb   = sel ? bus1.Rd_Wb       : bus0.Rd_Wb;
   assign rdest = sel ? bus1.Rd_Dest     : bus0.Rd_Dest;
   assign armed = sel ? bus1.Armed       : bus0.Armed;
   assign trig  = sel ? bus1.Triggered   : bus0.Triggered;
   assign done  = sel ? bus1.Done        : bus0.Done;
   assign cnt   = sel ? bus1.Entry_Count : bus0.Entry_Count;
   assign cyc   = sel ? bus1.Cycle_Count : bus0.Cycle_Count;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Arm-cycle sample uses a PC that must never show up in readout.
   task automatic do_arm(input logic [1:0] m);
      mode = m;
      arm  = 1'b1;
      pc   = 32'h0000_FFFC;
      step();
      arm  = 1'b0;
   endtask

   // Feeds PCs 0,4,8,... until Done or the budget runs out; n = samples fed.
   // Sample 2 writes nothing to $5, sample 6 writes $5, others write $3.
   task automatic run_until_done(input int budget, output int n);
      n  = 0;
      pc = 32'h0;
      while (n < budget && !done) begin
         rw   = (n != 2);
         dest = (n == 2 || n == 6) ? 5'd5 : 5'd3;
         step();
         n++;
         if (!done) pc = pc + 32'h4;
      end
   endtask

   task automatic read_all(input string tag, input logic [31:0] first, input int n, input bit stall);
      int idx = 0;
      int k   = 0;
      while (idx < n && k < 200) begin
         rdy = stall ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
         check({tag, "_valid"}, 64'(rv), 64'd1);
         check({tag, "_pc"},    64'(rpc), 64'(first + 32'(4 * idx)));
         check({tag, "_inst"},  64'(rinst), 64'(inst_of(first + 32'(4 * idx))));
         check({tag, "_data"},  64'(rdata), 64'(data_of(first + 32'(4 * idx))));
         step();
         if (rdy) idx++;
         k++;
      end
      rdy = 1'b0;
      check({tag, "_xfers"},    64'(idx), 64'(n));
      check({tag, "_end_valid"}, 64'(rv), 64'd0);
      check({tag, "_end_done"},  64'(done), 64'd1);
   endtask

   initial begin
      int n;
      Reset = 1'b1;
      arm   = 1'b0;
      mode  = 2'd0;
      taddr = 32'h0;
      treg  = 5'd0;
      rdy   = 1'b0;
      sel   = 1'b0;
      pc    = 32'h0;
      rw    = 1'b0;
      dest  = 5'd0;

      repeat (2) @(posedge Clk);
      #1;
      check("rst_armed", 64'(armed), 64'd0);
      check("rst_trig",  64'(trig),  64'd0);
      check("rst_done",  64'(done),  64'd0);
      check("rst_cnt",   64'(cnt),   64'd0);
      check("rst_cyc",   64'(cyc),   64'd0);
      check("rst_rv",    64'(rv),    64'd0);
      check("rst_rpc",   64'(rpc),   64'd0);
      Reset = 1'b0;
      step();

      // PC match at 0x20: 9 pre/trigger samples + 4 post.
      taddr = 32'h20;
      do_arm(2'd0);
      check("a_armed", 64'(armed), 64'd1);
      check("a_cnt0",  64'(cnt),   64'd0);
      check("a_cyc0",  64'(cyc),   64'd0);
      run_until_done(100, n);
      check("a_samples", 64'(n),     64'd13);
      check("a_cnt",     64'(cnt),   64'd13);
      check("a_cyc",     64'(cyc),   64'd13);
      check("a_trig",    64'(trig),  64'd1);
      check("a_armed1",  64'(armed), 64'd0);
      check("a_done",    64'(done),  64'd1);
      pc = 32'h20;
      step();
      step();
      check("a_cnt_hold", 64'(cnt), 64'd13);
      check("a_cyc_hold", 64'(cyc), 64'd13);
      read_all("a", 32'h0, 13, 1'b0);

      // PC match at 0x80: buffer wraps, oldest 0x54 .. newest 0x90, stalled readout.
      taddr = 32'h80;
      do_arm(2'd0);
      run_until_done(100, n);
      check("b_samples", 64'(n),   64'd37);
      check("b_cnt",     64'(cnt), 64'd16);
      read_all("b", 32'h54, 16, 1'b1);

      // Register-write match on $5 with POST_TRIG=0.
      sel  = 1'b1;
      treg = 5'd5;
      do_arm(2'd1);
      run_until_done(100, n);
      check("c_samples", 64'(n),    64'd7);
      check("c_cnt",     64'(cnt),  64'd7);
      check("c_cyc",     64'(cyc),  64'd7);
      check("c_done",    64'(done), 64'd1);
      rdy = 1'b1;
      step();
      step();
      check("c_e2_pc", 64'(rpc), 64'h8);
      check("c_e2_wb", 64'(rwb), 64'd0);
      repeat (4) step();
      check("c_last_pc",   64'(rpc),   64'h18);
      check("c_last_wb",   64'(rwb),   64'd1);
      check("c_last_dest", 64'(rdest), 64'd5);
      check("c_last_data", 64'(rdata), 64'(data_of(32'h18)));
      step();
      rdy = 1'b0;
      check("c_end_valid", 64'(rv),   64'd0);
      check("c_end_done",  64'(done), 64'd1);

      // Reset pulsed while in POST.
      sel   = 1'b0;
      taddr = 32'h20;
      do_arm(2'd0);
      run_until_done(10, n);
      check("d_trig",  64'(trig), 64'd1);
      check("d_done",  64'(done), 64'd0);
      check("d_cnt",   64'(cnt),  64'd10);
      #2;
      Reset = 1'b1;
      #1;
      check("d_rst_armed", 64'(armed), 64'd0);
      check("d_rst_trig",  64'(trig),  64'd0);
      check("d_rst_cnt",   64'(cnt),   64'd0);
      check("d_rst_cyc",   64'(cyc),   64'd0);
      check("d_rst_rv",    64'(rv),    64'd0);
      @(negedge Clk);
      Reset = 1'b0;
      step();
      step();
      check("d_idle_armed", 64'(armed), 64'd0);
      check("d_idle_cyc",   64'(cyc),   64'd0);
      check("d_idle_cnt",   64'(cnt),   64'd0);

      // Immediate trigger: 1 trigger sample + 4 post.
      do_arm(2'd2);
      run_until_done(20, n);
      check("e_samples", 64'(n),    64'd5);
      check("e_cnt",     64'(cnt),  64'd5);
      check("e_cyc",     64'(cyc),  64'd5);
      check("e_done",    64'(done), 64'd1);
      rdy = 1'b1;
      check("e_pc0", 64'(rpc), 64'h0);
      step();
      check("e_pc1", 64'(rpc), 64'h4);

      // Arm with Rd_Ready high mid-readout, then run never-trigger mode.
      do_arm(2'd3);
      rdy = 1'b0;
      check("f_rv",    64'(rv),    64'd0);
      check("f_armed", 64'(armed), 64'd1);
      check("f_cyc",   64'(cyc),   64'd0);
      check("f_cnt",   64'(cnt),   64'd0);
      pc = 32'h0;
      for (int i = 0; i < 100; i++) begin
         step();
         pc = pc + 32'h4;
      end
      check("f_done",   64'(done),  64'd0);
      check("f_armed2", 64'(armed), 64'd1);
      check("f_cnt16",  64'(cnt),   64'd16);
      check("f_cyc100", 64'(cyc),   64'd100);
      check("f_rv2",    64'(rv),    64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
